// File: rtl/uart_tx_core.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_core
// Description : Parametrised UART transmitter. Contains the control FSM, baud
//               counter, one-entry holding register and shift register. The
//               holding register lets the next byte be accepted while the
//               current frame is on the line, so frames go back-to-back.
//
//               Frame: start (0), DATA_BITS data bits LSB first, optional
//               parity bit, STOP_BITS stop bits (1). Every bit lasts exactly
//               CLKS_PER_BIT clk cycles. All outputs are registered.
//
//               Optional feature macro: UART_TX_PARITY_EN
//                 defined   -> a parity bit follows the data bits
//                              (even parity, or odd when PARITY_ODD=1)
//                 undefined -> no parity state or parity logic
//
// Parameters  : DATA_BITS     data bits per frame, 5..9
//               CLKS_PER_BIT  clk cycles per serial bit, >= 2
//               STOP_BITS     1 or 2
//               PARITY_ODD    0 even / 1 odd (parity builds only)
//
// Ports       : clk       in   system clock, rising edge
//               rst_b     in   asynchronous reset, active-low
//               tx_data   in   DATA_BITS byte to send
//               tx_valid  in   tx_data valid
//               tx_ready  out  holding register empty (accept on valid&ready)
//               txd       out  serial line, idle high, LSB first
//               busy      out  frame in progress
//
// Revision    : 1.0  initial release
// ============================================================================
module uart_tx_core #(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic                 clk,
    input  logic                 rst_b,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 txd,
    output logic                 busy
);

    localparam int c_BAUD_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int c_IDX_W  = 4;

    localparam logic [c_BAUD_W-1:0] c_BAUD_LAST = c_BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [c_IDX_W-1:0]  c_DATA_LAST = c_IDX_W'(DATA_BITS - 1);
    localparam logic [c_IDX_W-1:0]  c_STOP_LAST = c_IDX_W'(STOP_BITS - 1);

    // Reject illegal configurations at elaboration time.
    generate
        if ((DATA_BITS < 5) || (DATA_BITS > 9) || (CLKS_PER_BIT < 2) ||
            (STOP_BITS < 1) || (STOP_BITS > 2) ||
            (PARITY_ODD < 0) || (PARITY_ODD > 1)) begin : g_bad_params
            $error("uart_tx_core: illegal parameter value");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4
    } state_t;

    state_t                 r_state;
    logic [c_BAUD_W-1:0]    r_baud_cnt;
    logic [c_IDX_W-1:0]     r_bit_idx;   // data bit index, reused as stop bit index
    logic [DATA_BITS-1:0]   r_shift;
    logic [DATA_BITS-1:0]   r_hold;
    logic                   r_hold_empty;
    logic                   r_txd;
    logic                   r_busy;

    state_t                 w_state_next;
    logic [c_BAUD_W-1:0]    w_baud_next;
    logic [c_IDX_W-1:0]     w_idx_next;
    logic [DATA_BITS-1:0]   w_shift_next;
    logic                   w_load;
    logic                   w_txd_next;
    logic                   w_bit_end;
    logic                   w_accept;

`ifdef UART_TX_PARITY_EN
    localparam logic c_PARITY_INV = (PARITY_ODD != 0);
    logic r_parity;
    logic w_parity_next;

    // Parity is latched from the value moving into the shift register, so it
    // is stable for the whole frame regardless of shifting.
    assign w_parity_next = w_load ? ((^r_hold) ^ c_PARITY_INV) : r_parity;
`endif

    assign w_bit_end = (r_baud_cnt == c_BAUD_LAST);
    assign w_accept  = tx_valid & r_hold_empty;

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_baud_next  = r_baud_cnt + 1'b1;
        w_idx_next   = r_bit_idx;
        w_shift_next = r_shift;
        w_load       = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_baud_next = '0;
                if (!r_hold_empty) begin
                    w_load       = 1'b1;
                    w_shift_next = r_hold;
                    w_idx_next   = '0;
                    w_state_next = S_START;
                end
            end

            S_START: begin
                if (w_bit_end) begin
                    w_baud_next  = '0;
                    w_idx_next   = '0;
                    w_state_next = S_DATA;
                end
            end

            S_DATA: begin
                if (w_bit_end) begin
                    w_baud_next = '0;
                    if (r_bit_idx == c_DATA_LAST) begin
                        w_idx_next   = '0;
`ifdef UART_TX_PARITY_EN
                        w_state_next = S_PARITY;
`else
                        w_state_next = S_STOP;
`endif
                    end else begin
                        w_idx_next   = r_bit_idx + 1'b1;
                        w_shift_next = {1'b0, r_shift[DATA_BITS-1:1]};
                    end
                end
            end

`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (w_bit_end) begin
                    w_baud_next  = '0;
                    w_idx_next   = '0;
                    w_state_next = S_STOP;
                end
            end
`endif

            S_STOP: begin
                if (w_bit_end) begin
                    w_baud_next = '0;
                    if (r_bit_idx == c_STOP_LAST) begin
                        w_idx_next = '0;
                        // A byte already waiting goes straight into a new
                        // start bit; a byte accepted on this same edge waits
                        // for IDLE to pick it up on the next edge.
                        if (!r_hold_empty) begin
                            w_load       = 1'b1;
                            w_shift_next = r_hold;
                            w_state_next = S_START;
                        end else begin
                            w_state_next = S_IDLE;
                        end
                    end else begin
                        w_idx_next = r_bit_idx + 1'b1;
                    end
                end
            end

            default: begin
                w_baud_next  = '0;
                w_idx_next   = '0;
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Line level is decided from the next state so txd can be a flop.
    always_comb begin
        w_txd_next = 1'b1;
        case (w_state_next)
            S_START:  w_txd_next = 1'b0;
            S_DATA:   w_txd_next = w_shift_next[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: w_txd_next = w_parity_next;
`endif
            default:  w_txd_next = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_state      <= S_IDLE;
            r_baud_cnt   <= '0;
            r_bit_idx    <= '0;
            r_shift      <= '0;
            r_hold       <= '0;
            r_hold_empty <= 1'b1;
            r_txd        <= 1'b1;
            r_busy       <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_baud_cnt <= w_baud_next;
            r_bit_idx  <= w_idx_next;
            r_shift    <= w_shift_next;
            r_txd      <= w_txd_next;
            r_busy     <= (w_state_next != S_IDLE);
            // Load and accept never coincide: load needs a full holding
            // register, accept needs an empty one.
            if (w_load) begin
                r_hold_empty <= 1'b1;
            end else if (w_accept) begin
                r_hold       <= tx_data;
                r_hold_empty <= 1'b0;
            end
        end
    end

`ifdef UART_TX_PARITY_EN
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_parity <= 1'b0;
        end else begin
            r_parity <= w_parity_next;
        end
    end
`endif

    assign tx_ready = r_hold_empty;
    assign txd      = r_txd;
    assign busy     = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_core
// Description : Self-checking bench for uart_tx_core. Two instances with
//               DATA_BITS=8, CLKS_PER_BIT=4: u_dut0 (STOP_BITS=1, even
//               parity) and u_dut1 (STOP_BITS=2, odd parity). A frame-level
//               model predicts txd/busy/tx_ready every cycle; directed tests
//               add hand-computed literal checks.
// Revision    : 1.0  initial release
// ============================================================================
module tb_uart_tx_core;

    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int PBITS = 1;
`else
    localparam int PBITS = 0;
`endif
    localparam int FL0 = CPB * (1 + 8 + PBITS + 1);
    localparam int FL1 = CPB * (1 + 8 + PBITS + 2);

    logic       clk;
    logic       rst_b;
    logic [1:0] tx_valid;
    logic [7:0] tx_data [2];
    logic       tx_ready0, tx_ready1;
    logic       txd0, txd1;
    logic       busy0, busy1;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    uart_tx_core #(.DATA_BITS(8), .CLKS_PER_BIT(CPB), .STOP_BITS(1), .PARITY_ODD(0)) u_dut0 (
        .clk(clk), .rst_b(rst_b), .tx_data(tx_data[0]), .tx_valid(tx_valid[0]),
        .tx_ready(tx_ready0), .txd(txd0), .busy(busy0)
    );

    uart_tx_core #(.DATA_BITS(8), .CLKS_PER_BIT(CPB), .STOP_BITS(2), .PARITY_ODD(1)) u_dut1 (
        .clk(clk), .rst_b(rst_b), .tx_data(tx_data[1]), .tx_valid(tx_valid[1]),
        .tx_ready(tx_ready1), .txd(txd1), .busy(busy1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int get_txd(input int i);
        return (i == 0) ? int'(txd0) : int'(txd1);
    endfunction
    function automatic int get_busy(input int i);
        return (i == 0) ? int'(busy0) : int'(busy1);
    endfunction
    function automatic int get_ready(input int i);
        return (i == 0) ? int'(tx_ready0) : int'(tx_ready1);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, cyc);
        end
    endtask

    // ------------------------------------------------------------------------
    // Frame-level model: a frame is a list of line levels, each held for CPB
    // cycles, starting on the edge the frame begins.
    // ------------------------------------------------------------------------
    logic        m_hold_full [2];
    logic [7:0]  m_hold      [2];
    logic        m_active    [2];
    int          m_fs        [2];
    logic [15:0] m_bits      [2];
    int          m_nbits     [2];

    function automatic int stop_of(input int i);
        return (i == 0) ? 1 : 2;
    endfunction
    function automatic int podd_of(input int i);
        return (i == 0) ? 0 : 1;
    endfunction

    function automatic void build_frame(input int i, input logic [7:0] d);
        logic [15:0] b;
        int          n;
        int          ones;
        int          par;
        b    = '1;
        n    = 0;
        ones = 0;
        b[n] = 1'b0;
        n++;
        for (int k = 0; k < 8; k++) begin
            b[n] = d[k];
            ones += int'(d[k]);
            n++;
        end
        par = (podd_of(i) == 0) ? (ones % 2) : (1 - (ones % 2));
`ifdef UART_TX_PARITY_EN
        b[n] = (par != 0);
        n++;
`else
        if (par > 1) b[0] = 1'b1;
`endif
        n += stop_of(i);
        m_bits[i]  = b;
        m_nbits[i] = n;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            m_hold_full[i] = 1'b0;
            m_hold[i]      = '0;
            m_active[i]    = 1'b0;
            m_fs[i]        = 0;
            m_bits[i]      = '1;
            m_nbits[i]     = 0;
        end
    endfunction

    function automatic void model_edge(input int e);
        logic hf;
        for (int i = 0; i < 2; i++) begin
            hf = m_hold_full[i];
            if (m_active[i] && ((e - m_fs[i]) == m_nbits[i] * CPB))
                m_active[i] = 1'b0;
            if (!m_active[i] && hf) begin
                build_frame(i, m_hold[i]);
                m_fs[i]        = e;
                m_active[i]    = 1'b1;
                m_hold_full[i] = 1'b0;
            end
            if (!hf && tx_valid[i]) begin
                m_hold[i]      = tx_data[i];
                m_hold_full[i] = 1'b1;
            end
        end
    endfunction

    function automatic int exp_txd(input int i);
        if (!m_active[i]) return 1;
        return int'(m_bits[i][(cyc - m_fs[i]) / CPB]);
    endfunction

    // Model update and compare, once per cycle on the falling edge. Inputs
    // only change 1 time unit after a falling edge, so they are stable here.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_b) model_reset();
            else        model_edge(cyc);
            for (int i = 0; i < 2; i++) begin
                check($sformatf("model_txd%0d", i),   get_txd(i),   exp_txd(i));
                check($sformatf("model_busy%0d", i),  get_busy(i),  int'(m_active[i]));
                check($sformatf("model_ready%0d", i), get_ready(i), int'(!m_hold_full[i]));
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_to(input int t);
        while (cyc < t) tick();
    endtask

    task automatic send(input int i, input logic [7:0] d, output int acc);
        int n;
        n = 0;
        while (get_ready(i) != 1 && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) check("send_ready_timeout", 0, 1);
        tx_data[i]  = d;
        tx_valid[i] = 1'b1;
        tick();
        acc         = cyc;
        tx_valid[i] = 1'b0;
    endtask

    task automatic wait_idle(input int i);
        int n;
        n = 0;
        while ((get_busy(i) != 0 || get_ready(i) != 1) && n < 400) begin
            tick();
            n++;
        end
        if (n >= 400) check("idle_timeout", 0, 1);
        tick();
    endtask

    // ------------------------------------------------------------------------
    // Directed tests
    // ------------------------------------------------------------------------
    initial begin
        int a, b, n;
        rst_b      = 1'b1;
        tx_valid   = '0;
        tx_data[0] = '0;
        tx_data[1] = '0;

        // Reset without a clock edge
        #1 rst_b = 1'b0;
        #1;
        check("rst_txd0", int'(txd0), 1);
        check("rst_ready0", int'(tx_ready0), 1);
        check("rst_busy0", int'(busy0), 0);
        check("rst_txd1", int'(txd1), 1);
        check("rst_ready1", int'(tx_ready1), 1);
        check("rst_busy1", int'(busy1), 0);
        tick();
        tick();
        rst_b = 1'b1;
        tick();

        // 0xA5: start, 1,0,1,0,0,1,0,1, [parity 0], stop
        send(0, 8'hA5, a);
        wait_to(a + 1);
        check("a5_start", int'(txd0), 0);
        check("a5_busy", int'(busy0), 1);
        check("a5_ready_back", int'(tx_ready0), 1);
        wait_to(a + 4);
        check("a5_start_end", int'(txd0), 0);
        wait_to(a + 5);
        check("a5_bit0", int'(txd0), 1);
        wait_to(a + 9);
        check("a5_bit1", int'(txd0), 0);
        wait_to(a + 33);
        check("a5_bit7", int'(txd0), 1);
        wait_to(a + 37);
`ifdef UART_TX_PARITY_EN
        check("a5_parity", int'(txd0), 0);
`else
        check("a5_stop", int'(txd0), 1);
`endif
        wait_to(a + FL0);
        check("a5_busy_last", int'(busy0), 1);
        wait_to(a + FL0 + 1);
        check("a5_busy_done", int'(busy0), 0);
        check("a5_idle_txd", int'(txd0), 1);
        wait_idle(0);

        // 0x00 then 0xFF back-to-back
        send(0, 8'h00, a);
        send(0, 8'hFF, b);
        check("b2b_accept_gap", b - a, 2);
        wait_to(a + FL0);
        check("b2b_stop", int'(txd0), 1);
        check("b2b_ready_held", int'(tx_ready0), 0);
        wait_to(a + FL0 + 1);
        check("b2b_start2", int'(txd0), 0);
        check("b2b_ready2", int'(tx_ready0), 1);
        check("b2b_busy2", int'(busy0), 1);
        wait_idle(0);

        // Accept on the same edge the previous frame ends with hold empty
        send(0, 8'h5A, a);
        wait_to(a + FL0);
        send(0, 8'hC3, b);
        check("sim_accept_edge", b - a, FL0 + 1);
        check("sim_idle_txd", int'(txd0), 1);
        check("sim_idle_busy", int'(busy0), 0);
        check("sim_hold_ready", int'(tx_ready0), 0);
        wait_to(b + 1);
        check("sim_start_txd", int'(txd0), 0);
        check("sim_start_busy", int'(busy0), 1);
        wait_idle(0);

        // Parity of 0x07 (three ones)
        send(0, 8'h07, a);
        wait_to(a + 37);
        check("p07_even_bit", int'(txd0), 1);
        wait_to(a + 41);
        check("p07_len0", int'(busy0), PBITS);
        wait_idle(0);
        send(1, 8'h07, a);
        wait_to(a + 37);
        check("p07_odd_bit", int'(txd1), 1 - PBITS);
        wait_to(a + FL1);
        check("p07_busy_last1", int'(busy1), 1);
        wait_to(a + FL1 + 1);
        check("p07_done1", int'(busy1), 0);
        wait_idle(1);

        // Reset in data bit 3 with a second byte in the holding register
        send(0, 8'h3C, a);
        send(0, 8'h99, b);
        wait_to(a + 18);
        check("mid_ready_before", int'(tx_ready0), 0);
        rst_b = 1'b0;
        #1;
        check("mid_rst_txd", int'(txd0), 1);
        check("mid_rst_ready", int'(tx_ready0), 1);
        check("mid_rst_busy", int'(busy0), 0);
        tick();
        tick();
        rst_b = 1'b1;
        tick();
        tick();
        check("mid_no_resume", int'(busy0), 0);
        send(0, 8'h3C, a);
        wait_to(a + 5);
        check("3c_bit0", int'(txd0), 0);
        wait_to(a + 13);
        check("3c_bit2", int'(txd0), 1);
        wait_to(a + 29);
        check("3c_bit6", int'(txd0), 0);
        wait_idle(0);

        // Two stop bits between 0x55 and 0xAA
        send(1, 8'h55, a);
        send(1, 8'hAA, b);
        wait_to(a + 36);
        check("s2_bit7", int'(txd1), 0);
        wait_to(a + 37);
        n = 0;
        while (txd1 == 1'b1 && n < 30) begin
            n++;
            tick();
        end
        check("s2_high_run", n, 8 + 4 * PBITS);
        check("s2_next_busy", int'(busy1), 1);
        wait_idle(1);
        wait_idle(0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
